uart_rx_fsm: RTL and testbench

Receive-side sequencer for the UART RX path. Detects the start edge on `RX_IN` and runs the per-bit edge counter and bit counter. Drives `data_sampling` through `Data_Sample_EN`/`Edge_Counter` and consumes its `Sampled_bit`. Deserializes data LSB-first, checks start/parity/stop, and presents one parallel byte per frame with a valid pulse and error flags.

---
 rtl/uart_rx_pkg.sv | 29 ++
 rtl/uart_rx_fsm_edge_bit_counter.sv | 54 +++++
 rtl/uart_rx_fsm.sv | 184 ++++++++++++++++++
 tb/tb_uart_rx_fsm.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared state type, prescaler constants and helpers for the UART receive sequencer
package uart_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_t;

  localparam logic [4:0] PRESC_4  = 5'd4;
  localparam logic [4:0] PRESC_8  = 5'd8;
  localparam logic [4:0] PRESC_16 = 5'd16;

  localparam int DEFAULT_DATA_WIDTH = 8;

  // Unsupported oversampling ratios fall back to 8 so the counters always
  // run with a sane bit period.
  function automatic logic [4:0] map_prescaler(input logic [4:0] raw);
    logic [4:0] mapped;
    case (raw)
      PRESC_4, PRESC_8, PRESC_16: mapped = raw;
      default:                    mapped = PRESC_8;
    endcase
    return mapped;
  endfunction

endpackage

// File: rtl/uart_rx_fsm_edge_bit_counter.sv
// rtl/uart_rx_fsm_edge_bit_counter.sv - per-bit edge counter and received-bit counter
// Ports:
//   CLK, RST          clock, synchronous active-high reset
//   enable            counters run while high, cleared to 0 while low
//   bit_count_en      bit counter advances at bit-end only while high
//   presc             latched oversampling ratio (4, 8 or 16)
//   Edge_Counter      edge index inside the current bit, 0..presc-1
//   bit_end           high on the last edge of a bit (counter wrap cycle)
//   bit_count         number of bit-ends seen while bit_count_en was high
module edge_bit_counter
  import uart_rx_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic       enable,
  input  logic       bit_count_en,
  input  logic [4:0] presc,
  output logic [4:0] Edge_Counter,
  output logic       bit_end,
  output logic [3:0] bit_count
);

  logic [4:0] edge_q, edge_d;
  logic [3:0] bit_count_q, bit_count_d;

  assign bit_end      = enable && (edge_q == (presc - 5'd1));
  assign Edge_Counter = edge_q;
  assign bit_count    = bit_count_q;

  always_comb begin
    edge_d      = edge_q;
    bit_count_d = bit_count_q;
    if (!enable) begin
      edge_d      = 5'd0;
      bit_count_d = 4'd0;
    end else begin
      edge_d = bit_end ? 5'd0 : edge_q + 5'd1;
      if (bit_end && bit_count_en) begin
        bit_count_d = bit_count_q + 4'd1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      edge_q      <= 5'd0;
      bit_count_q <= 4'd0;
    end else begin
      edge_q      <= edge_d;
      bit_count_q <= bit_count_d;
    end
  end

endmodule

// File: rtl/uart_rx_fsm.sv
// rtl/uart_rx_fsm.sv - UART receive sequencer: start detect, bit sequencing, deserialize and frame checks
// Ports:
//   CLK, RST          oversampling clock, synchronous active-high reset
//   RX_IN             serial line, idle high
//   prescaler         oversampling ratio, latched at frame start
//   PAR_EN, PAR_TYP   parity present / odd parity, latched at frame start
//   Sampled_bit       majority-voted bit from the sampler
//   Data_Sample_EN    sampler enable, high while a frame is in progress
//   Edge_Counter      edge index inside the current bit
//   P_DATA            last cleanly received byte
//   Data_Valid        one-cycle pulse, clean frame
//   Par_Err           one-cycle pulse, parity mismatch
//   Stop_Err          one-cycle pulse, stop bit sampled low
//   Strt_Glitch       one-cycle pulse, start bit sampled high
//   Busy              high whenever the sequencer is not idle
module uart_rx_fsm
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [4:0]            prescaler,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  Sampled_bit,
  output logic                  Data_Sample_EN,
  output logic [4:0]            Edge_Counter,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  Data_Valid,
  output logic                  Par_Err,
  output logic                  Stop_Err,
  output logic                  Strt_Glitch,
  output logic                  Busy
);

  localparam logic [3:0] LAST_BIT = 4'(DATA_WIDTH - 1);

  rx_state_t             state_q, state_d;
  logic [4:0]            presc_q, presc_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic                  bit_hold_q, bit_hold_d;
  logic                  par_bad_q, par_bad_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
  logic                  data_valid_q, data_valid_d;
  logic                  par_err_q, par_err_d;
  logic                  stop_err_q, stop_err_d;
  logic                  strt_glitch_q, strt_glitch_d;
  logic                  busy_q, busy_d;

  logic       bit_end;
  logic [3:0] bit_count;
  logic [4:0] edge_cnt;
  logic [4:0] strobe_edge;
  logic       strobe;
  logic       bit_val;

  edge_bit_counter u_counter (
    .CLK          (CLK),
    .RST          (RST),
    .enable       (busy_q),
    .bit_count_en (state_q == ST_DATA),
    .presc        (presc_q),
    .Edge_Counter (edge_cnt),
    .bit_end      (bit_end),
    .bit_count    (bit_count)
  );

  // At 4x oversampling the last edge is too close to the next bit, so the
  // bit is taken one edge earlier and held until bit-end.
  assign strobe_edge = (presc_q == PRESC_4) ? 5'd2 : (presc_q - 5'd1);
  assign strobe      = busy_q && (edge_cnt == strobe_edge);
  assign bit_val     = strobe ? Sampled_bit : bit_hold_q;

  always_comb begin
    state_d       = state_q;
    presc_d       = presc_q;
    par_en_d      = par_en_q;
    par_typ_d     = par_typ_q;
    par_bad_d     = par_bad_q;
    shift_d       = shift_q;
    p_data_d      = p_data_q;
    bit_hold_d    = strobe ? Sampled_bit : bit_hold_q;
    data_valid_d  = 1'b0;
    par_err_d     = 1'b0;
    stop_err_d    = 1'b0;
    strt_glitch_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!RX_IN) begin
          presc_d   = map_prescaler(prescaler);
          par_en_d  = PAR_EN;
          par_typ_d = PAR_TYP;
          par_bad_d = 1'b0;
          state_d   = ST_START;
        end
      end
      ST_START: begin
        if (bit_end) begin
          if (bit_val) begin
            strt_glitch_d = 1'b1;
            state_d       = ST_IDLE;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          shift_d = {bit_val, shift_q[DATA_WIDTH-1:1]};
          if (bit_count == LAST_BIT) begin
            state_d = par_en_q ? ST_PARITY : ST_STOP;
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          par_bad_d = bit_val ^ (^shift_q) ^ par_typ_q;
          state_d   = ST_STOP;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          stop_err_d   = ~bit_val;
          par_err_d    = par_bad_q;
          data_valid_d = bit_val & ~par_bad_q;
          if (bit_val && !par_bad_q) begin
            p_data_d = shift_q;
          end
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= ST_IDLE;
      presc_q       <= 5'd0;
      par_en_q      <= 1'b0;
      par_typ_q     <= 1'b0;
      par_bad_q     <= 1'b0;
      bit_hold_q    <= 1'b0;
      shift_q       <= '0;
      p_data_q      <= '0;
      data_valid_q  <= 1'b0;
      par_err_q     <= 1'b0;
      stop_err_q    <= 1'b0;
      strt_glitch_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      presc_q       <= presc_d;
      par_en_q      <= par_en_d;
      par_typ_q     <= par_typ_d;
      par_bad_q     <= par_bad_d;
      bit_hold_q    <= bit_hold_d;
      shift_q       <= shift_d;
      p_data_q      <= p_data_d;
      data_valid_q  <= data_valid_d;
      par_err_q     <= par_err_d;
      stop_err_q    <= stop_err_d;
      strt_glitch_q <= strt_glitch_d;
      busy_q        <= busy_d;
    end
  end

  assign Data_Sample_EN = busy_q;
  assign Busy           = busy_q;
  assign Edge_Counter   = edge_cnt;
  assign P_DATA         = p_data_q;
  assign Data_Valid     = data_valid_q;
  assign Par_Err        = par_err_q;
  assign Stop_Err       = stop_err_q;
  assign Strt_Glitch    = strt_glitch_q;

endmodule

// File: tb/tb_uart_rx_fsm.sv
// tb/tb_uart_rx_fsm.sv - self-checking bench for uart_rx_fsm
module tb_uart_rx_fsm;

  localparam int HN = 32768;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_in;
  logic [4:0] prescaler;
  logic       par_en;
  logic       par_typ;
  logic       sampled_bit;
  logic       sample_en;
  logic [4:0] edge_counter;
  logic [7:0] p_data;
  logic       data_valid;
  logic       par_err;
  logic       stop_err;
  logic       strt_glitch;
  logic       busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  logic [7:0] exp_pdata;

  typedef struct {
    int         c;
    logic [3:0] f;   // {dv, pe, se, sg}
    logic [7:0] pd;
  } ev_t;

  ev_t  ev_q [$];
  logic busy_hist [HN];
  logic sen_hist  [HN];
  logic [4:0] edge_hist [HN];

  uart_rx_fsm dut (
    .CLK            (clk),
    .RST            (rst),
    .RX_IN          (rx_in),
    .prescaler      (prescaler),
    .PAR_EN         (par_en),
    .PAR_TYP        (par_typ),
    .Sampled_bit    (sampled_bit),
    .Data_Sample_EN (sample_en),
    .Edge_Counter   (edge_counter),
    .P_DATA         (p_data),
    .Data_Valid     (data_valid),
    .Par_Err        (par_err),
    .Stop_Err       (stop_err),
    .Strt_Glitch    (strt_glitch),
    .Busy           (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (cyc < HN) begin
      busy_hist[cyc] <= busy;
      sen_hist[cyc]  <= sample_en;
      edge_hist[cyc] <= edge_counter;
    end
    if (data_valid || par_err || stop_err || strt_glitch)
      ev_q.push_back('{cyc, {data_valid, par_err, stop_err, strt_glitch}, p_data});
  end

  function automatic int legal_presc(input logic [4:0] r);
    return (r == 5'd4 || r == 5'd8 || r == 5'd16) ? int'(r) : 8;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rx_in = 1'b1;
    for (int i = 0; i < n; i++) begin
      sampled_bit = 1'($urandom);
      step();
    end
  endtask

  // Drives one frame as the sampler would see it: Sampled_bit carries the
  // true bit on the strobe edge and noise everywhere else.
  task automatic drive_frame(input logic [4:0] praw, input logic pen, input logic ptyp,
                             input logic [7:0] data, input logic pflip, input logic stop_bit,
                             input logic scramble, input int abort_bit, output int det);
    int   p, sidx, nb;
    logic fb [12];
    p    = legal_presc(praw);
    sidx = (p == 4) ? 2 : p - 1;
    nb   = pen ? 11 : 10;
    fb[0] = 1'b0;
    for (int i = 0; i < 8; i++) fb[i+1] = data[i];
    fb[9]  = pen ? (^data ^ ptyp ^ pflip) : stop_bit;
    fb[10] = stop_bit;
    fb[11] = 1'b1;
    prescaler   = praw;
    par_en      = pen;
    par_typ     = ptyp;
    rx_in       = 1'b0;
    sampled_bit = 1'($urandom);
    det = cyc;
    step();
    for (int k = 0; k < nb; k++) begin
      for (int e = 0; e < p; e++) begin
        if (k == abort_bit && e == 3) begin
          rst   = 1'b1;
          rx_in = 1'b1;
          step();
          rst = 1'b0;
          return;
        end
        if (scramble) begin
          prescaler = 5'($urandom_range(0, 31));
          par_en    = 1'($urandom);
          par_typ   = 1'($urandom);
        end
        rx_in       = fb[k];
        sampled_bit = (e == sidx) ? fb[k] : 1'($urandom);
        step();
      end
    end
    rx_in = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; rx_in = 1'b1; prescaler = 5'd8; par_en = 1'b0; par_typ = 1'b0; sampled_bit = 1'b0;
    step(); step();
    checks++;
    if ({busy, sample_en, data_valid, par_err, stop_err, strt_glitch} !== 6'b0) begin
      failures++;
      $display("FAIL reset_flags: got %b want 000000",
               {busy, sample_en, data_valid, par_err, stop_err, strt_glitch});
    end
    checks++;
    if (p_data !== 8'h00 || edge_counter !== 5'd0) begin
      failures++;
      $display("FAIL reset_data: got p_data=%h edge=%0d want 00/0", p_data, edge_counter);
    end
    rst = 1'b0;
    idle(3);
    checks++;
    if (busy !== 1'b0 || edge_counter !== 5'd0) begin
      failures++;
      $display("FAIL idle_after_reset: got busy=%b edge=%0d want 0/0", busy, edge_counter);
    end
    exp_pdata = 8'h00;
  endtask

  task automatic test_clean_frame();
    int det;
    ev_q.delete();
    drive_frame(5'd8, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b0, -1, det);
    idle(5);
    exp_pdata = 8'hA5;
    checks++;
    if (ev_q.size() != 1) begin
      failures++;
      $display("FAIL clean_events: got %0d events want 1", ev_q.size());
    end else begin
      checks++;
      if (ev_q[0].c != det + 81 || ev_q[0].f !== 4'b1000) begin
        failures++;
        $display("FAIL clean_pulse: got cycle=%0d flags=%b want cycle=%0d flags=1000",
                 ev_q[0].c - det, ev_q[0].f, 81);
      end
      checks++;
      if (ev_q[0].pd !== 8'hA5) begin
        failures++;
        $display("FAIL clean_pdata: got %h want a5", ev_q[0].pd);
      end
    end
    checks++;
    if ({busy_hist[det], busy_hist[det+1], busy_hist[det+80], busy_hist[det+81]} !== 4'b0110) begin
      failures++;
      $display("FAIL clean_busy: got %b want 0110",
               {busy_hist[det], busy_hist[det+1], busy_hist[det+80], busy_hist[det+81]});
    end
    checks++;
    if (edge_hist[det+1] !== 5'd0 || edge_hist[det+8] !== 5'd7 || edge_hist[det+9] !== 5'd0) begin
      failures++;
      $display("FAIL clean_edge: got %0d/%0d/%0d want 0/7/0",
               edge_hist[det+1], edge_hist[det+8], edge_hist[det+9]);
    end
    checks++;
    if (sen_hist[det] !== 1'b0 || sen_hist[det+5] !== 1'b1) begin
      failures++;
      $display("FAIL clean_sample_en: got %b%b want 01", sen_hist[det], sen_hist[det+5]);
    end
  endtask

  task automatic test_parity_error();
    int det;
    ev_q.delete();
    drive_frame(5'd16, 1'b1, 1'b0, 8'h0F, 1'b1, 1'b1, 1'b0, -1, det);
    idle(5);
    checks++;
    if (ev_q.size() != 1) begin
      failures++;
      $display("FAIL parity_events: got %0d events want 1", ev_q.size());
    end else begin
      checks++;
      if (ev_q[0].c != det + 177 || ev_q[0].f !== 4'b0100) begin
        failures++;
        $display("FAIL parity_pulse: got cycle=%0d flags=%b want cycle=177 flags=0100",
                 ev_q[0].c - det, ev_q[0].f);
      end
    end
    checks++;
    if (p_data !== exp_pdata) begin
      failures++;
      $display("FAIL parity_pdata_held: got %h want %h", p_data, exp_pdata);
    end
  endtask

  task automatic test_stop_error();
    int det;
    ev_q.delete();
    drive_frame(5'd8, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, -1, det);
    idle(5);
    checks++;
    if (ev_q.size() != 1) begin
      failures++;
      $display("FAIL stop_events: got %0d events want 1", ev_q.size());
    end else begin
      checks++;
      if (ev_q[0].c != det + 81 || ev_q[0].f !== 4'b0010) begin
        failures++;
        $display("FAIL stop_pulse: got cycle=%0d flags=%b want cycle=81 flags=0010",
                 ev_q[0].c - det, ev_q[0].f);
      end
    end
    checks++;
    if (p_data !== exp_pdata) begin
      failures++;
      $display("FAIL stop_pdata_held: got %h want %h", p_data, exp_pdata);
    end
  endtask

  task automatic test_start_glitch();
    int det;
    ev_q.delete();
    prescaler = 5'd8; par_en = 1'b0; par_typ = 1'b0;
    rx_in = 1'b0; sampled_bit = 1'($urandom);
    det = cyc;
    step();
    for (int e = 0; e < 8; e++) begin
      rx_in       = (e == 0) ? 1'b0 : 1'b1;
      sampled_bit = (e == 7) ? 1'b1 : 1'($urandom);
      step();
    end
    idle(12);
    checks++;
    if (ev_q.size() != 1) begin
      failures++;
      $display("FAIL glitch_events: got %0d events want 1", ev_q.size());
    end else begin
      checks++;
      if (ev_q[0].c != det + 9 || ev_q[0].f !== 4'b0001) begin
        failures++;
        $display("FAIL glitch_pulse: got cycle=%0d flags=%b want cycle=9 flags=0001",
                 ev_q[0].c - det, ev_q[0].f);
      end
    end
    checks++;
    if (busy_hist[det+8] !== 1'b1 || busy_hist[det+9] !== 1'b0) begin
      failures++;
      $display("FAIL glitch_busy: got %b%b want 10", busy_hist[det+8], busy_hist[det+9]);
    end
  endtask

  task automatic test_back_to_back();
    int d1, d2;
    ev_q.delete();
    drive_frame(5'd4, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1, 1'b0, -1, d1);
    drive_frame(5'd4, 1'b0, 1'b0, 8'hC3, 1'b0, 1'b1, 1'b0, -1, d2);
    idle(5);
    exp_pdata = 8'hC3;
    checks++;
    if (ev_q.size() != 2) begin
      failures++;
      $display("FAIL b2b_events: got %0d events want 2", ev_q.size());
    end else begin
      checks++;
      if (ev_q[0].c != d1 + 41 || ev_q[1].c != ev_q[0].c + 41) begin
        failures++;
        $display("FAIL b2b_timing: got %0d and %0d want 41 and 41",
                 ev_q[0].c - d1, ev_q[1].c - ev_q[0].c);
      end
      checks++;
      if (ev_q[0].f !== 4'b1000 || ev_q[1].f !== 4'b1000 ||
          ev_q[0].pd !== 8'h3C || ev_q[1].pd !== 8'hC3) begin
        failures++;
        $display("FAIL b2b_data: got %b/%h %b/%h want 1000/3c 1000/c3",
                 ev_q[0].f, ev_q[0].pd, ev_q[1].f, ev_q[1].pd);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int det;
    ev_q.delete();
    drive_frame(5'd8, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b1, 1'b0, 5, det);
    checks++;
    if ({busy, sample_en, data_valid, par_err, stop_err, strt_glitch} !== 6'b0 ||
        edge_counter !== 5'd0 || p_data !== 8'h00) begin
      failures++;
      $display("FAIL midreset_outputs: got flags=%b edge=%0d p_data=%h want 000000/0/00",
               {busy, sample_en, data_valid, par_err, stop_err, strt_glitch}, edge_counter, p_data);
    end
    exp_pdata = 8'h00;
    idle(20);
    checks++;
    if (ev_q.size() != 0) begin
      failures++;
      $display("FAIL midreset_no_pulse: got %0d events want 0", ev_q.size());
    end
    drive_frame(5'd8, 1'b0, 1'b0, 8'h81, 1'b0, 1'b1, 1'b0, -1, det);
    idle(5);
    exp_pdata = 8'h81;
    checks++;
    if (ev_q.size() != 1) begin
      failures++;
      $display("FAIL midreset_recover_events: got %0d events want 1", ev_q.size());
    end else begin
      checks++;
      if (ev_q[0].c != det + 81 || ev_q[0].f !== 4'b1000 || ev_q[0].pd !== 8'h81) begin
        failures++;
        $display("FAIL midreset_recover: got cycle=%0d flags=%b pd=%h want 81/1000/81",
                 ev_q[0].c - det, ev_q[0].f, ev_q[0].pd);
      end
    end
  endtask

  task automatic test_random();
    int         exp_c  [$];
    logic [3:0] exp_f  [$];
    logic [7:0] exp_pd [$];
    int         det, p, nb, n;
    logic [4:0] praw;
    logic       pen, ptyp, pflip, stp, dv;
    logic [7:0] data;
    ev_q.delete();
    for (int fr = 0; fr < 24; fr++) begin
      case ($urandom_range(0, 3))
        0:       praw = 5'd4;
        1:       praw = 5'd8;
        2:       praw = 5'd16;
        default: praw = 5'($urandom_range(0, 31));
      endcase
      pen   = 1'($urandom);
      ptyp  = 1'($urandom);
      data  = 8'($urandom);
      pflip = pen && ($urandom_range(0, 3) == 0);
      stp   = ($urandom_range(0, 3) != 0);
      drive_frame(praw, pen, ptyp, data, pflip, stp, 1'b1, -1, det);
      p  = legal_presc(praw);
      nb = pen ? 11 : 10;
      dv = stp && !pflip;
      if (dv) exp_pdata = data;
      exp_c.push_back(det + nb * p + 1);
      exp_f.push_back({dv, pflip, !stp, 1'b0});
      exp_pd.push_back(exp_pdata);
      idle($urandom_range(0, 3));
    end
    idle(6);
    checks++;
    if (ev_q.size() != exp_c.size()) begin
      failures++;
      $display("FAIL rand_events: got %0d events want %0d", ev_q.size(), exp_c.size());
    end
    n = (ev_q.size() < exp_c.size()) ? ev_q.size() : exp_c.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      if (ev_q[i].c != exp_c[i] || ev_q[i].f !== exp_f[i] || ev_q[i].pd !== exp_pd[i]) begin
        failures++;
        $display("FAIL rand_frame%0d: got cycle=%0d flags=%b pd=%h want cycle=%0d flags=%b pd=%h",
                 i, ev_q[i].c, ev_q[i].f, ev_q[i].pd, exp_c[i], exp_f[i], exp_pd[i]);
      end
    end
  endtask

  initial begin
    rst = 1'b1; rx_in = 1'b1; prescaler = 5'd8; par_en = 1'b0; par_typ = 1'b0; sampled_bit = 1'b0;
    exp_pdata = 8'h00;
    test_reset();
    test_clean_frame();
    test_parity_error();
    test_stop_error();
    test_start_glitch();
    test_back_to_back();
    test_reset_mid_frame();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
